// File: rtl/qsgmii_speed_cfg_ctrl_if.sv
// qsgmii_speed_cfg_ctrl_if: QSGMII core status/config bundle; SPEED_CHG_IRQ_EN adds speed-change flag signals
interface qsgmii_speed_cfg_ctrl_if #(parameter int NUM_CORES = 6);
  localparam int NCH = 4 * NUM_CORES;
  logic [2*NCH-1:0]     status_speed_in;
  logic [NCH-1:0]       link_status_in;
  logic [NCH-1:0]       speed_is_10_100;
  logic [NCH-1:0]       speed_is_100;
  logic [NUM_CORES-1:0] an_restart_config;
  logic [5:0]           configuration_vector;
  logic [15:0]          an_adv_config_vector;
  logic                 signal_detect;
`ifdef SPEED_CHG_IRQ_EN
  logic [NCH-1:0]       speed_chg_clr;
  logic [NCH-1:0]       speed_chg_flag;
  logic                 speed_chg_irq;
  modport master (
    output status_speed_in, link_status_in, speed_chg_clr,
    input  speed_is_10_100, speed_is_100, an_restart_config, configuration_vector,
           an_adv_config_vector, signal_detect, speed_chg_flag, speed_chg_irq
  );
  modport slave (
    input  status_speed_in, link_status_in, speed_chg_clr,
    output speed_is_10_100, speed_is_100, an_restart_config, configuration_vector,
           an_adv_config_vector, signal_detect, speed_chg_flag, speed_chg_irq
  );
`else
  modport master (
    output status_speed_in, link_status_in,
    input  speed_is_10_100, speed_is_100, an_restart_config, configuration_vector,
           an_adv_config_vector, signal_detect
  );
  modport slave (
    input  status_speed_in, link_status_in,
    output speed_is_10_100, speed_is_100, an_restart_config, configuration_vector,
           an_adv_config_vector, signal_detect
  );
`endif
endinterface

// File: rtl/qsgmii_speed_cfg_ctrl.sv
// qsgmii_speed_cfg_ctrl: per-channel speed debounce and per-core AN restart for QSGMII cores.
// Defining SPEED_CHG_IRQ_EN adds sticky speed-change flags and an irq output.
module qsgmii_speed_cfg_ctrl #(
  parameter int                     NUM_CORES       = 6,
  parameter int                     STABLE_CYC      = 1024,
  parameter int                     RESTART_TIMEOUT = 125000,
  parameter int                     RESTART_PULSE   = 16,
  parameter logic [4*NUM_CORES-1:0] CH_EN_MASK      = '1,
  parameter logic [5:0]             CFG_VECTOR      = 6'h30,
  parameter logic [15:0]            AN_ADV_VECTOR   = 16'h0021
) (
  input logic                  clk,
  input logic                  rst_n,
  qsgmii_speed_cfg_ctrl_if.slave bus
);
  localparam int NCH = 4 * NUM_CORES;
  localparam int CW  = $clog2(STABLE_CYC + 1);
  localparam int TW  = $clog2(RESTART_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC - 1);
  localparam logic [TW-1:0] T_MAX   = TW'(RESTART_TIMEOUT);
  localparam logic [TW-1:0] P_MAX   = TW'(RESTART_PULSE);
  localparam logic [TW-1:0] T_ONE   = TW'(1);
  typedef enum logic [1:0] {IDLE, COUNT, PULSE} st_t;
  logic [2*NCH-1:0]     spd_m, s_spd;
  logic [NCH-1:0]       lnk_m, s_lnk;
  logic [1:0]           cand [NCH];
  logic [CW-1:0]        cnt  [NCH];
  logic [NCH-1:0]       r10, r100;
  logic [NUM_CORES-1:0] down, restart;
  st_t                  st [NUM_CORES], st_n [NUM_CORES];
  logic [TW-1:0]        tm [NUM_CORES], tm_n [NUM_CORES];
  assign bus.speed_is_10_100      = r10;
  assign bus.speed_is_100         = r100;
  assign bus.an_restart_config    = restart;
  assign bus.configuration_vector = CFG_VECTOR;
  assign bus.an_adv_config_vector = AN_ADV_VECTOR;
  assign bus.signal_detect        = 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      spd_m <= '0;
      s_spd <= '0;
      lnk_m <= '0;
      s_lnk <= '0;
    end else begin
      spd_m <= bus.status_speed_in;
      s_spd <= spd_m;
      lnk_m <= bus.link_status_in;
      s_lnk <= lnk_m;
    end
  // A code must be seen unchanged for STABLE_CYC samples before it reaches the outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        cand[c] <= 2'b10;
        cnt[c]  <= '0;
      end
      r10  <= '0;
      r100 <= '0;
    end else
      for (int c = 0; c < NCH; c++)
        if (CH_EN_MASK[c]) begin
          if (s_spd[2*c+:2] != cand[c]) begin
            cand[c] <= s_spd[2*c+:2];
            cnt[c]  <= '0;
          end else if (cnt[c] == CNT_MAX) begin
            if (cand[c] != 2'b11) begin
              r10[c]  <= cand[c] != 2'b10;
              r100[c] <= cand[c] == 2'b01;
            end
          end else
            cnt[c] <= cnt[c] + 1'b1;
        end
  always_comb
    for (int k = 0; k < NUM_CORES; k++)
      down[k] = |(~s_lnk[4*k+:4] & CH_EN_MASK[4*k+:4]);
  // The timer counts link-down time in COUNT and pulse length in PULSE
  always_comb
    for (int k = 0; k < NUM_CORES; k++) begin
      st_n[k] = st[k];
      tm_n[k] = tm[k];
      if (st[k] == IDLE) begin
        if (down[k]) begin
          st_n[k] = COUNT;
          tm_n[k] = T_ONE;
        end
      end else if (st[k] == COUNT) begin
        st_n[k] = !down[k] ? IDLE : (tm[k] == T_MAX) ? PULSE : COUNT;
        tm_n[k] = !down[k] ? '0 : (tm[k] == T_MAX) ? T_ONE : tm[k] + T_ONE;
      end else if (tm[k] == P_MAX) begin
        st_n[k] = down[k] ? COUNT : IDLE;
        tm_n[k] = down[k] ? T_ONE : '0;
      end else
        tm_n[k] = tm[k] + T_ONE;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < NUM_CORES; k++) begin
        st[k] <= IDLE;
        tm[k] <= '0;
      end
      restart <= '0;
    end else
      for (int k = 0; k < NUM_CORES; k++) begin
        st[k]      <= st_n[k];
        tm[k]      <= tm_n[k];
        restart[k] <= st_n[k] == PULSE;
      end
`ifdef SPEED_CHG_IRQ_EN
  logic [NCH-1:0] p10, p100, flag;
  logic           irq;
  assign bus.speed_chg_flag = flag;
  assign bus.speed_chg_irq  = irq;
  // A set in the same cycle as a clear takes priority
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      p10  <= '0;
      p100 <= '0;
      flag <= '0;
      irq  <= 1'b0;
    end else begin
      p10  <= r10;
      p100 <= r100;
      flag <= (flag & ~bus.speed_chg_clr) | (r10 ^ p10) | (r100 ^ p100);
      irq  <= |flag;
    end
`endif
endmodule

// File: tb/tb_qsgmii_speed_cfg_ctrl.sv
// tb_qsgmii_speed_cfg_ctrl: randomized and directed checks against a window-rule speed model and timeout arithmetic
module tb_qsgmii_speed_cfg_ctrl;
  localparam int NC = 2;
  localparam int NCH = 8;
  localparam int SC = 4;
  localparam int TO = 20;
  localparam int PL = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  int n = 0;
  logic [2*NCH-1:0] spd;
  logic [NCH-1:0] lnk;
  logic [2*NCH-1:0] rawq[$];
  logic [NCH-1:0] e10, e100, pe10, pe100, eflag, clr_v;
  logic eirq;
  qsgmii_speed_cfg_ctrl_if #(.NUM_CORES(NC)) bus();
  qsgmii_speed_cfg_ctrl #(.NUM_CORES(NC), .STABLE_CYC(SC), .RESTART_TIMEOUT(TO), .RESTART_PULSE(PL)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [1:0] syn(int m, int c);
    logic [2*NCH-1:0] v;
    if (m < 3) return 2'b00;
    v = rawq[m-3];
    return v[2*c+:2];
  endfunction
  task automatic drive();
    bus.status_speed_in = spd;
    bus.link_status_in = lnk;
`ifdef SPEED_CHG_IRQ_EN
    bus.speed_chg_clr = clr_v;
`endif
  endtask
  task automatic model_reset();
    rawq.delete();
    n = 0;
    e10 = '0; e100 = '0; pe10 = '0; pe100 = '0; eflag = '0; eirq = 1'b0;
  endtask
  task automatic step(input logic [NC-1:0] er);
    logic [NCH-1:0] chg;
    logic [1:0] v;
    bit same;
    @(posedge clk);
    rawq.push_back(bus.status_speed_in);
    n++;
    chg = (e10 ^ pe10) | (e100 ^ pe100);
    eirq = |eflag;
    eflag = (eflag & ~clr_v) | chg;
    pe10 = e10;
    pe100 = e100;
    if (n >= SC + 1)
      for (int c = 0; c < NCH; c++) begin
        v = syn(n, c);
        same = 1;
        for (int j = 1; j <= SC; j++) if (syn(n - j, c) != v) same = 0;
        if (same && v != 2'b11) begin
          e10[c] = v != 2'b10;
          e100[c] = v == 2'b01;
        end
      end
    @(negedge clk);
    total++;
    if (bus.speed_is_10_100 !== e10 || bus.speed_is_100 !== e100) begin
      bad++;
      $display("FAIL speed edge=%0d got 10_100=%h 100=%h exp %h %h", n, bus.speed_is_10_100, bus.speed_is_100, e10, e100);
    end
    total++;
    if (bus.an_restart_config !== er) begin
      bad++;
      $display("FAIL an_restart edge=%0d got %b exp %b", n, bus.an_restart_config, er);
    end
`ifdef SPEED_CHG_IRQ_EN
    total++;
    if (bus.speed_chg_flag !== eflag || bus.speed_chg_irq !== eirq) begin
      bad++;
      $display("FAIL chg_flag edge=%0d got flag=%h irq=%b exp %h %b", n, bus.speed_chg_flag, bus.speed_chg_irq, eflag, eirq);
    end
`endif
  endtask
  task automatic test_reset();
    spd = 16'hAAAA; lnk = '1; clr_v = '0;
    drive();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    total++;
    if (bus.speed_is_10_100 !== 8'h00 || bus.speed_is_100 !== 8'h00 || bus.an_restart_config !== 2'b00) begin
      bad++;
      $display("FAIL reset_outputs got %h %h %b exp 00 00 00", bus.speed_is_10_100, bus.speed_is_100, bus.an_restart_config);
    end
    total++;
    if (bus.configuration_vector !== 6'h30 || bus.an_adv_config_vector !== 16'h0021 || bus.signal_detect !== 1'b1) begin
      bad++;
      $display("FAIL static_outputs got %h %h %b exp 30 0021 1", bus.configuration_vector, bus.an_adv_config_vector, bus.signal_detect);
    end
    rst_n = 1'b1;
    repeat (8) step('0);
  endtask
  task automatic test_step_ch5();
    spd[11:10] = 2'b01;
    drive();
    for (int k = 1; k <= SC + 3; k++) begin
      step('0);
      total++;
      if ({bus.speed_is_10_100[5], bus.speed_is_100[5]} !== ((k == SC + 3) ? 2'b11 : 2'b00)) begin
        bad++;
        $display("FAIL ch5_latency edge=%0d got %b%b", k, bus.speed_is_10_100[5], bus.speed_is_100[5]);
      end
    end
    repeat (4) step('0);
  endtask
  task automatic test_glitch_hold();
    spd[5:4] = 2'b01;
    drive();
    repeat (3) step('0);
    spd[5:4] = 2'b10;
    drive();
    repeat (10) step('0);
    total++;
    if ({bus.speed_is_10_100[2], bus.speed_is_100[2]} !== 2'b00) begin
      bad++;
      $display("FAIL ch2_glitch got %b%b exp 00", bus.speed_is_10_100[2], bus.speed_is_100[2]);
    end
    spd[7:6] = 2'b00;
    drive();
    repeat (8) step('0);
    spd[7:6] = 2'b11;
    drive();
    repeat (10) step('0);
    total++;
    if ({bus.speed_is_10_100[3], bus.speed_is_100[3]} !== 2'b10) begin
      bad++;
      $display("FAIL ch3_reserved_hold got %b%b exp 10", bus.speed_is_10_100[3], bus.speed_is_100[3]);
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 5) == 0) spd[2*c+:2] = 2'($urandom_range(0, 3));
      clr_v = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
      drive();
      step('0);
    end
    spd = 16'hAAAA; clr_v = '0;
    drive();
    repeat (8) step('0);
  endtask
  task automatic test_speed_irq();
    clr_v = '1;
    spd[1:0] = 2'b00;
    drive();
    repeat (10) step('0);
    clr_v = '0;
    spd[1:0] = 2'b01;
    drive();
    repeat (10) step('0);
    clr_v = 8'h01;
    drive();
    step('0);
    clr_v = '0;
    spd[1:0] = 2'b10;
    drive();
    repeat (10) step('0);
  endtask
  function automatic logic [NC-1:0] pulse_exp(int k);
    return (k >= TO + 3 && (k - (TO + 3)) % (TO + PL) < PL) ? 2'b10 : 2'b00;
  endfunction
  task automatic test_link_timeout();
    int ch;
    ch = $urandom_range(4, 7);
    lnk[ch] = 1'b0;
    drive();
    for (int k = 1; k <= 60; k++) step(pulse_exp(k));
    lnk = '1;
    drive();
    repeat (12) step('0);
  endtask
  task automatic test_up_mid_count();
    lnk[6] = 1'b0;
    drive();
    repeat (10) step('0);
    lnk = '1;
    drive();
    repeat (30) step('0);
  endtask
  task automatic test_up_mid_pulse();
    lnk[6] = 1'b0;
    drive();
    repeat (TO + 2) step('0);
    lnk = '1;
    drive();
    repeat (PL) step(2'b10);
    repeat (30) step('0);
  endtask
  task automatic test_reset_mid_pulse();
    lnk[7] = 1'b0;
    drive();
    for (int k = 1; k <= TO + 4; k++) step(pulse_exp(k));
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.an_restart_config !== 2'b00 || bus.speed_is_10_100 !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid_pulse got %b %h exp 00 00", bus.an_restart_config, bus.speed_is_10_100);
    end
    test_reset();
  endtask
  initial begin
    spd = 16'hAAAA; lnk = '1; clr_v = '0;
    model_reset();
    drive();
    test_reset();
    test_step_ch5();
    test_glitch_hold();
    test_random();
`ifdef SPEED_CHG_IRQ_EN
    test_speed_irq();
`endif
    test_link_timeout();
    test_up_mid_count();
    test_up_mid_pulse();
    test_reset_mid_pulse();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
